simi_argmin: RTL and testbench
==============================

Name: simi_argmin

Overview:
- Controller and comparator directly downstream of the Similarity stage.
- Sweeps all stored class hypervectors, driving the class-memory address and Similarity `en` one class per cycle.
- Consumes each registered Hamming distance and keeps a running minimum.
- Returns the nearest class index and its distance through a valid/ready result port; this is the final classification step of inference.

Parameters:
- NUM_CLASS, 16, number of class hypervectors swept; must be ≥ 2.
- SIMI_W, $clog2(`DIM)+1, width of a similarity value (11 for DIM=1024).
- CLS_W, $clog2(NUM_CLASS), class index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request one classification; sampled only in IDLE.
- busy  out  1  high in any state other than IDLE.
- cls_addr  out  CLS_W  class memory address; combinational-read memory feeds Similarity operand b.
- sim_en  out  1  drives Similarity en.
- simi  in  SIMI_W  registered distance from Similarity.
- res_vld  out  1  result valid.
- res_rdy  in  1  result accepted.
- res_idx  out  CLS_W  index of the nearest class.
- res_simi  out  SIMI_W  distance of the nearest class.

Behaviour:
- Single clock domain; reset is asynchronous and active-low. Reset values: state=IDLE; busy, sim_en and res_vld 0; cls_addr, res_idx and res_simi 0; internal pipeline flags 0.
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE: if start=1, go to SCAN with addr counter=0. Otherwise stay.
- SCAN:
  - sim_en=1, cls_addr=counter.
  - Counter increments each cycle.
  - After the cycle with cls_addr=NUM_CLASS-1, go to DRAIN.
- DRAIN (one cycle): sim_en=0. The last distance is compared. Next state is DONE.
- DONE:
  - res_vld=1; res_idx and res_simi are held stable.
  - On res_vld&res_rdy, go to IDLE.
  - res_rdy is allowed to be high before res_vld.
- Pipeline alignment:
  - Similarity adds one register, so the simi seen in cycle k+1 belongs to the address issued in cycle k.
  - cmp_vld is sim_en delayed one cycle; cmp_idx is cls_addr delayed one cycle.
- Compare, when cmp_vld=1:
  - For the first class of a sweep (cmp_idx=0), load best unconditionally.
  - Otherwise, update only if simi < best_simi (strict), so ties keep the lowest index.
  - res_idx and res_simi are the best registers themselves.
- Latency:
  - start sampled at the edge ending cycle 0 → SCAN in cycles 1..NUM_CLASS → DRAIN in cycle NUM_CLASS+1 → res_vld in cycle NUM_CLASS+2.
  - For NUM_CLASS=16, res_vld is first high in cycle 18.
- Throughput: one classification per NUM_CLASS+3 cycles when res_rdy is held high. A new start is accepted only from IDLE, the cycle after the handshake.
- start while busy is ignored: no queuing, no restart.
- simi is ignored whenever cmp_vld=0.
- Reset mid-sweep: everything returns to reset values immediately, with no partial result.
- Best registers are not cleared on accept; they are reloaded by the next sweep's first compare.

Optional Feature:
- Macro: SIMI_REJECT_EN.
- Defined:
  - Adds port rej_thr (in, SIMI_W) and port res_rej (out, 1).
  - res_rej = (res_simi > rej_thr), registered at the DRAIN→DONE transition. rej_thr is sampled in DRAIN.
  - res_rej is valid only with res_vld; reset value 0.
  - Marks inputs too far from every class as unknown.
- Undefined: neither port exists and behaviour is otherwise identical.

Decomposition:
- Shared package hdc_pkg holds:
  - SIMI_W and CLS_W derivation functions or localparams.
  - The state enum type argmin_state_e {IDLE, SCAN, DRAIN, DONE}.
- Sub-module argmin_cmp holds:
  - The cmp_vld/cmp_idx delay registers.
  - The best_simi/best_idx registers with the first-load and strict-less update rule.
- The FSM and address counter remain in simi_argmin.

Test Plan:
- Distances 500,300,700,…, with a minimum of 120 at class 9, NUM_CLASS=16, res_rdy=1: res_idx=9, res_simi=120, res_vld rises in cycle 18, busy is 0 in cycle 19.
- Tie: classes 3 and 11 both 64, all others greater: res_idx=3.
- All distances 0; then a second sweep with all distances 1024: results idx 0/simi 0, then idx 0/simi 1024, proving the first compare reloads.
- res_rdy held 0 for 10 cycles in DONE, and start pulsed during SCAN and DONE: res_vld and the result are stable, a single sweep only, no extra sim_en pulses.
- rst_n asserted at cycle 8 of a sweep: all outputs 0 asynchronously. A following start completes a normal sweep with the correct result.
- SIMI_REJECT_EN defined, rej_thr=200: a minimum of 250 gives res_rej=1, a minimum of 200 gives res_rej=0.

Source files
------------

// File: rtl/hdc_pkg.sv
// hdc_pkg: shared widths and argmin state type for the HDC inference path
// DIM defaults to 1024 when not supplied by the build.
`ifndef DIM
`define DIM 1024
`endif
package hdc_pkg;
    localparam int DIM = `DIM;
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} argmin_state_e;
    function automatic int simi_w(input int dim);
        return $clog2(dim) + 1;
    endfunction
    function automatic int cls_w(input int n);
        return $clog2(n);
    endfunction
endpackage

// File: rtl/argmin_cmp.sv
// argmin_cmp: aligns the similarity pipeline and keeps the running minimum
// Ports: clk, rst_n (async active-low); en/idx are sim_en/cls_addr of the
// current cycle; simi is the registered distance for last cycle's address;
// best_idx/best_simi hold the running minimum; nxt_simi (SIMI_REJECT_EN only)
// is the value best_simi takes at the coming edge.
module argmin_cmp #(
    parameter int SIMI_W = 11,
    parameter int CLS_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [CLS_W-1:0]  idx,
    input  logic [SIMI_W-1:0] simi,
    output logic [CLS_W-1:0]  best_idx,
    output logic [SIMI_W-1:0] best_simi
`ifdef SIMI_REJECT_EN
    ,
    output logic [SIMI_W-1:0] nxt_simi
`endif
);
    logic             cmp_vld;
    logic [CLS_W-1:0] cmp_idx;
    logic             upd;
    // class 0 reloads unconditionally so stale results never survive a sweep;
    // strict less keeps the lowest index on ties
    assign upd = cmp_vld && (cmp_idx == '0 || simi < best_simi);
`ifdef SIMI_REJECT_EN
    assign nxt_simi = upd ? simi : best_simi;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_vld   <= 1'b0;
            cmp_idx   <= '0;
            best_idx  <= '0;
            best_simi <= '0;
        end else begin
            cmp_vld <= en;
            cmp_idx <= idx;
            if (upd) begin
                best_idx  <= cmp_idx;
                best_simi <= simi;
            end
        end
    end
endmodule

// File: rtl/simi_argmin.sv
// simi_argmin: sweeps all class hypervectors and returns the nearest class
// Ports: clk, rst_n (async active-low); start requests a classification
// (sampled in IDLE only); busy high outside IDLE; cls_addr/sim_en drive the
// class memory and Similarity stage; simi is its registered distance;
// res_vld/res_rdy handshake res_idx/res_simi.
// Optional macro SIMI_REJECT_EN adds rej_thr (in) and res_rej (out).
module simi_argmin
    import hdc_pkg::*;
#(
    parameter int NUM_CLASS = 16,
    parameter int SIMI_W    = simi_w(DIM),
    parameter int CLS_W     = cls_w(NUM_CLASS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic [CLS_W-1:0]  cls_addr,
    output logic              sim_en,
    input  logic [SIMI_W-1:0] simi,
    output logic              res_vld,
    input  logic              res_rdy,
    output logic [CLS_W-1:0]  res_idx,
    output logic [SIMI_W-1:0] res_simi
`ifdef SIMI_REJECT_EN
    ,
    input  logic [SIMI_W-1:0] rej_thr,
    output logic              res_rej
`endif
);
    argmin_state_e    state_q, state_d;
    logic [CLS_W-1:0] cnt_q, cnt_d;
    logic             last;
    assign last = cnt_q == CLS_W'(NUM_CLASS - 1);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                state_d = start ? SCAN : IDLE;
                cnt_d   = '0;
            end
            SCAN: begin
                state_d = last ? DRAIN : SCAN;
                cnt_d   = last ? '0 : cnt_q + CLS_W'(1);
            end
            DRAIN: state_d = DONE;
            DONE:  state_d = res_rdy ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    assign busy     = state_q != IDLE;
    assign sim_en   = state_q == SCAN;
    assign cls_addr = cnt_q;
    assign res_vld  = state_q == DONE;
`ifdef SIMI_REJECT_EN
    logic [SIMI_W-1:0] nxt_simi;
    // the last compare lands on the same edge, so judge its outcome directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            res_rej <= 1'b0;
        else if (state_q == DRAIN)
            res_rej <= nxt_simi > rej_thr;
    end
`endif
    argmin_cmp #(.SIMI_W(SIMI_W), .CLS_W(CLS_W)) u_cmp (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (sim_en),
        .idx       (cls_addr),
        .simi      (simi),
        .best_idx  (res_idx),
        .best_simi (res_simi)
`ifdef SIMI_REJECT_EN
        ,
        .nxt_simi  (nxt_simi)
`endif
    );
endmodule

// File: tb/tb_simi_argmin.sv
// tb_simi_argmin: directed checks of the argmin sweep with a Similarity stand-in
module tb_simi_argmin;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic [3:0]  cls_addr;
    logic        sim_en;
    logic [10:0] simi;
    logic        res_vld;
    logic        res_rdy = 1'b1;
    logic [3:0]  res_idx;
    logic [10:0] res_simi;
    logic [10:0] tbl [16];
    int total = 0;
    int bad = 0;
    int vc, ec;
`ifdef SIMI_REJECT_EN
    logic [10:0] rej_thr = 11'd200;
    logic        res_rej;
`endif

    always #5 clk = ~clk;

    // registered distance; a small junk value when idle must never win
    always @(posedge clk or negedge rst_n)
        if (!rst_n) simi <= '0;
        else        simi <= sim_en ? tbl[cls_addr] : 11'd5;

    simi_argmin dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .cls_addr (cls_addr),
        .sim_en   (sim_en),
        .simi     (simi),
        .res_vld  (res_vld),
        .res_rdy  (res_rdy),
        .res_idx  (res_idx),
        .res_simi (res_simi)
`ifdef SIMI_REJECT_EN
        ,
        .rej_thr  (rej_thr),
        .res_rej  (res_rej)
`endif
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // start in cycle 0, run until res_vld (bounded); optional extra start pulse in cycle `pulse`
    task automatic run_sweep(input int pulse, output int vld_c, output int en_c);
        int c = 0;
        en_c = 0;
        start = 1'b1;
        do begin
            cyc();
            c++;
            start = (c == pulse);
            if (sim_en) en_c++;
        end while (!res_vld && c < 40);
        start = 1'b0;
        vld_c = c;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) tbl[i] = 11'd0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_sim_en", sim_en, 0);
        chk("rst_addr", cls_addr, 0);
        chk("rst_vld", res_vld, 0);
        chk("rst_idx", res_idx, 0);
        chk("rst_simi", res_simi, 0);
        rst_n = 1'b1;
        cyc();

        tbl = '{500, 300, 700, 640, 410, 333, 900, 222, 181, 120, 777, 130, 555, 999, 121, 1000};
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("scan_busy", busy, 1);
        chk("scan_en", sim_en, 1);
        chk("scan_addr0", cls_addr, 0);
        cyc();
        chk("scan_addr1", cls_addr, 1);
        repeat (3) cyc();
        chk("scan_addr4", cls_addr, 4);
        repeat (20) cyc();
        chk("min_back_idle", busy, 0);

        run_sweep(0, vc, ec);
        chk("min_vld_cycle", vc, 18);
        chk("min_en_pulses", ec, 16);
        chk("min_idx", res_idx, 9);
        chk("min_simi", res_simi, 120);
        cyc();
        chk("min_busy_c19", busy, 0);
        chk("min_vld_c19", res_vld, 0);

        for (int i = 0; i < 16; i++) tbl[i] = 11'd200;
        tbl[3] = 11'd64;
        tbl[11] = 11'd64;
        run_sweep(0, vc, ec);
        chk("tie_vld_cycle", vc, 18);
        chk("tie_idx", res_idx, 3);
        chk("tie_simi", res_simi, 64);
        cyc();

        for (int i = 0; i < 16; i++) tbl[i] = 11'd0;
        run_sweep(0, vc, ec);
        chk("zero_idx", res_idx, 0);
        chk("zero_simi", res_simi, 0);
        cyc();
        for (int i = 0; i < 16; i++) tbl[i] = 11'd1024;
        run_sweep(0, vc, ec);
        chk("reload_idx", res_idx, 0);
        chk("reload_simi", res_simi, 1024);
        cyc();

        for (int i = 0; i < 16; i++) tbl[i] = 11'd300 + 11'(i);
        tbl[15] = 11'd77;
        res_rdy = 1'b0;
        run_sweep(5, vc, ec);
        chk("stall_vld_cycle", vc, 18);
        chk("stall_en_pulses", ec, 16);
        for (int i = 1; i <= 10; i++) begin
            start = (i == 3);
            cyc();
            chk("stall_vld", res_vld, 1);
            chk("stall_idx", res_idx, 15);
            chk("stall_simi", res_simi, 77);
            chk("stall_no_en", sim_en, 0);
        end
        start = 1'b0;
        res_rdy = 1'b1;
        cyc();
        chk("stall_release_busy", busy, 0);
        cyc();
        chk("stall_no_requeue", busy, 0);

        tbl = '{500, 300, 700, 640, 410, 333, 900, 222, 181, 120, 777, 130, 555, 999, 121, 1000};
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (7) cyc();
        chk("mid_addr7", cls_addr, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_en", sim_en, 0);
        chk("arst_addr", cls_addr, 0);
        chk("arst_vld", res_vld, 0);
        chk("arst_idx", res_idx, 0);
        chk("arst_simi", res_simi, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();
        run_sweep(0, vc, ec);
        chk("post_rst_vld_cycle", vc, 18);
        chk("post_rst_idx", res_idx, 9);
        chk("post_rst_simi", res_simi, 120);
        cyc();

`ifdef SIMI_REJECT_EN
        for (int i = 0; i < 16; i++) tbl[i] = 11'd900;
        tbl[5] = 11'd250;
        run_sweep(0, vc, ec);
        chk("rej_idx", res_idx, 5);
        chk("rej_hi", res_rej, 1);
        cyc();
        tbl[5] = 11'd200;
        run_sweep(0, vc, ec);
        chk("rej_eq_simi", res_simi, 200);
        chk("rej_eq", res_rej, 0);
        cyc();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
